// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, consuming one
// operand bit pair per clock (LSB first). Result {co, sum} = a + b + ci.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic [1:0]       fsm_state
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_s;
    logic [WIDTH-1:0] sh_s_next;
    logic             carry;
    logic             bit_s;
    logic             carry_next;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    assign bit_s      = sh_a[0] ^ sh_b[0] ^ carry;
    assign carry_next = (sh_a[0] & sh_b[0]) | (carry & (sh_a[0] ^ sh_b[0]));
    assign last_bit   = (cnt == CW'(WIDTH - 1));
    assign fsm_state  = state;

    // New sum bits enter at the MSB so that after WIDTH shifts bit 0 is the LSB.
    generate
        if (WIDTH == 1) begin : g_one
            assign sh_s_next = bit_s;
        end else begin : g_many
            assign sh_s_next = {bit_s, sh_s[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            co    <= 1'b0;
            sh_a  <= '0;
            sh_b  <= '0;
            sh_s  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        carry <= ci;
                        sh_s  <= '0;
                        cnt   <= '0;
                        state <= S_RUN;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    carry <= carry_next;
                    sh_s  <= sh_s_next;
                    cnt   <= cnt + CW'(1);
                    // Outputs only move on the completion edge, never mid-operation.
                    if (last_bit) begin
                        sum   <= sh_s_next;
                        co    <= carry_next;
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
